// File: rtl/osnt_bram_pkg.sv
// Shared constants and lane helpers for the OSNT replay/capture memory.
// Pure elaboration-time content; no logic, no latency, no backpressure.
package osnt_bram_pkg;

  localparam int LANE_WIDTH     = 32;
  localparam int RDW_OLD        = 0;
  localparam int RDW_NEW        = 1;
  localparam int RD_LATENCY_MAX = 4;

  // Merge helper works on the widest supported word; callers cast in and out.
  localparam int DATA_WIDTH_MAX = 2048;
  localparam int LANES_MAX      = DATA_WIDTH_MAX / LANE_WIDTH;

  function automatic int lanes(input int data_width);
    return data_width / LANE_WIDTH;
  endfunction

  function automatic logic [DATA_WIDTH_MAX-1:0] lane_merge(
    input logic [DATA_WIDTH_MAX-1:0] old_word,
    input logic [DATA_WIDTH_MAX-1:0] new_word,
    input logic [LANES_MAX-1:0]      lane_en
  );
    logic [DATA_WIDTH_MAX-1:0] merged;
    merged = old_word;
    for (int i = 0; i < LANES_MAX; i++) begin
      if (lane_en[i]) begin
        merged[i*LANE_WIDTH +: LANE_WIDTH] = new_word[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/osnt_bram_rd_pipe.sv
// Valid/data delay line behind the array read stage; DEPTH cycles, data zeroed at the last stage.
// Always accepts one entry per cycle, no backpressure; async clear drops everything in flight.
module osnt_bram_rd_pipe #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 736
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  if (DEPTH == 0) begin : g_bypass
    assign out_valid = in_valid;
    assign out_data  = in_valid ? in_data : '0;
  end else begin : g_shift
    logic [DEPTH-1:0]      vld_q;
    logic [DATA_WIDTH-1:0] dat_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          dat_q[i] <= '0;
        end
      end else begin
        vld_q[0] <= in_valid;
        dat_q[0] <= (DEPTH == 1 && !in_valid) ? '0 : in_data;
        for (int i = 1; i < DEPTH; i++) begin
          vld_q[i] <= vld_q[i-1];
          dat_q[i] <= (i == DEPTH - 1 && !vld_q[i-1]) ? '0 : dat_q[i-1];
        end
      end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = dat_q[DEPTH-1];
  end

endmodule

// File: rtl/osnt_bram_pipe.sv
// Simple dual-port lane-writable packet memory with RD_LATENCY-cycle pipelined reads.
// No backpressure: one write and one read accepted every cycle; collisions counted, saturating.
module osnt_bram_pipe
  import osnt_bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 736,
  parameter int RD_LATENCY = 2,
  parameter int RDW_MODE   = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          bram_clk,
  input  logic                          bram_rstn,
  input  logic                          wr_en,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [lanes(DATA_WIDTH)-1:0]  wr_lane_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          rd_en,
  input  logic [ADDR_WIDTH-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  output logic [CNT_WIDTH-1:0]          collision_cnt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NLANE = lanes(DATA_WIDTH);

  if (RD_LATENCY < 1 || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
    $fatal(1, "osnt_bram_pipe: RD_LATENCY must be 1..4");
  end
  if (DATA_WIDTH % LANE_WIDTH != 0 || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_bad_width
    $fatal(1, "osnt_bram_pipe: DATA_WIDTH must be a multiple of 32 and <= 2048");
  end
  if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_bad_mode
    $fatal(1, "osnt_bram_pipe: RDW_MODE must be 0 or 1");
  end

  (* ram_style = "ultra" *)
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  collision;
  logic [DATA_WIDTH-1:0] fwd_word;
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;

  assign collision = rd_en & wr_en & (rd_addr == wr_addr) & (|wr_lane_en);

  // Storage is never reset, so URAM inference is not blocked.
  always_ff @(posedge bram_clk) begin
    for (int i = 0; i < NLANE; i++) begin
      if (wr_en && wr_lane_en[i]) begin
        mem[wr_addr][i*LANE_WIDTH +: LANE_WIDTH] <= wr_data[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  always_comb begin
    fwd_word = DATA_WIDTH'(lane_merge(DATA_WIDTH_MAX'(mem[rd_addr]),
                                      DATA_WIDTH_MAX'(wr_data),
                                      LANES_MAX'(wr_lane_en)));
  end

  // Non-blocking array read yields pre-write contents; new-data mode forwards enabled lanes.
  always_ff @(posedge bram_clk or negedge bram_rstn) begin
    if (!bram_rstn) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_en;
      if (rd_en) begin
        s1_data <= (RDW_MODE == RDW_NEW && collision) ? fwd_word : mem[rd_addr];
      end
    end
  end

  always_ff @(posedge bram_clk or negedge bram_rstn) begin
    if (!bram_rstn) begin
      collision_cnt <= '0;
    end else if (collision && collision_cnt != {CNT_WIDTH{1'b1}}) begin
      collision_cnt <= collision_cnt + CNT_WIDTH'(1);
    end
  end

  osnt_bram_rd_pipe #(
    .DEPTH      (RD_LATENCY - 1),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_pipe (
    .clk       (bram_clk),
    .rst_n     (bram_rstn),
    .in_valid  (s1_valid),
    .in_data   (s1_data),
    .out_valid (rd_valid),
    .out_data  (rd_data)
  );

endmodule

// File: tb/tb_osnt_bram_pipe.sv
// Four differently parametrised memories share one stimulus stream and are scored cycle by cycle
// against a timestamped behavioural model of memory contents, read delivery and collision counting.
`timescale 1ns/1ps
module tb_osnt_bram_pipe;

  localparam int AW   = 11;
  localparam int NW   = 2048;
  localparam int MAXW = 736;
  localparam int MAXL = 23;
  localparam int NI   = 4;

  function automatic int dw_of(input int g);
    return (g == 0) ? 736 : 128;
  endfunction
  function automatic int lat_of(input int g);
    case (g)
      0:       return 2;
      1:       return 1;
      2:       return 3;
      default: return 4;
    endcase
  endfunction
  function automatic int mode_of(input int g);
    return (g == 1 || g == 3) ? 1 : 0;
  endfunction
  function automatic int cw_of(input int g);
    return (g == 1 || g == 2) ? 4 : 16;
  endfunction

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr_en = 1'b0;
  logic            rd_en = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [AW-1:0]   rd_addr = '0;
  logic [MAXL-1:0] wr_lane_en = '0;
  logic [MAXW-1:0] wr_data = '0;

  logic [MAXW-1:0] obs_data [NI];
  logic            obs_vld  [NI];
  logic [15:0]     obs_cnt  [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DW = dw_of(g);
    localparam int CW = cw_of(g);
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          v;
    osnt_bram_pipe #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .RD_LATENCY (lat_of(g)),
      .RDW_MODE   (mode_of(g)),
      .CNT_WIDTH  (CW)
    ) dut (
      .bram_clk      (clk),
      .bram_rstn     (rst_n),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_lane_en    (wr_lane_en[DW/32-1:0]),
      .wr_data       (wr_data[DW-1:0]),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .rd_data       (d),
      .rd_valid      (v),
      .collision_cnt (c)
    );
    assign obs_data[g] = MAXW'(d);
    assign obs_vld[g]  = v;
    assign obs_cnt[g]  = 16'(c);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [MAXW-1:0] act, input logic [MAXW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  // Model: word contents per instance, plus expected output keyed by the cycle it must appear in.
  logic [MAXW-1:0] mdl_mem [NI][NW];
  logic [MAXW-1:0] exp_dat [NI][8];
  bit              exp_vld [NI][8];
  int              mdl_cnt [NI];
  int              cyc = 0;
  logic [MAXW-1:0] m_word;
  logic [MAXL-1:0] m_en;
  bit              m_hit;

  always @(posedge clk) begin
    cyc++;
    for (int g = 0; g < NI; g++) begin
      exp_vld[g][(cyc + 7) % 8] = 1'b0;
      if (!rst_n) begin
        for (int s = 0; s < 8; s++) exp_vld[g][s] = 1'b0;
        mdl_cnt[g] = 0;
      end else begin
        m_en = '0;
        for (int i = 0; i < dw_of(g) / 32; i++) m_en[i] = wr_lane_en[i];
        m_hit = wr_en && rd_en && (wr_addr == rd_addr) && (m_en != '0);
        if (rd_en) begin
          m_word = mdl_mem[g][rd_addr];
          if (m_hit && mode_of(g) == 1) begin
            for (int i = 0; i < MAXL; i++)
              if (m_en[i]) m_word[i*32 +: 32] = wr_data[i*32 +: 32];
          end
          // Registered at this edge, visible after edge cyc + latency - 1.
          exp_vld[g][(cyc + lat_of(g) - 1) % 8] = 1'b1;
          exp_dat[g][(cyc + lat_of(g) - 1) % 8] = m_word;
        end
        if (m_hit && mdl_cnt[g] < (1 << cw_of(g)) - 1) mdl_cnt[g]++;
        if (wr_en) begin
          for (int i = 0; i < MAXL; i++)
            if (m_en[i]) mdl_mem[g][wr_addr][i*32 +: 32] = wr_data[i*32 +: 32];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      bit              ev;
      logic [MAXW-1:0] ed;
      logic [MAXW-1:0] ec;
      if (!rst_n) begin
        ev = 1'b0;
        ed = '0;
        ec = '0;
      end else begin
        ev = exp_vld[g][cyc % 8];
        ed = ev ? exp_dat[g][cyc % 8] : '0;
        ec = MAXW'(mdl_cnt[g]);
      end
      check($sformatf("vld%0d@%0d", g, cyc), MAXW'(obs_vld[g]), MAXW'(ev));
      check($sformatf("data%0d@%0d", g, cyc), obs_data[g], ed);
      check($sformatf("cnt%0d@%0d", g, cyc), MAXW'(obs_cnt[g]), ec);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
    wr_lane_en = '0;
  endtask

  task automatic do_write(input int a, input logic [31:0] pat, input logic [MAXL-1:0] en);
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_lane_en = en;
    wr_data = {MAXL{pat}};
    tick();
    idle();
  endtask

  task automatic do_read(input int a);
    rd_en = 1'b1;
    rd_addr = AW'(a);
    tick();
    idle();
  endtask

  task automatic pulse_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    idle();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    for (int a = 0; a < NW; a++) begin
      wr_en = 1'b1;
      wr_addr = AW'(a);
      wr_lane_en = '1;
      wr_data = {MAXL{32'(a)}};
      tick();
    end
    idle();
    tick();

    for (int a = 0; a < NW; a++) begin
      rd_en = 1'b1;
      rd_addr = AW'(a);
      tick();
    end
    idle();
    repeat (6) tick();

    do_write(5, 32'hA5A5A5A5, '1);
    tick();
    do_read(5);
    repeat (6) tick();

    do_write(3, 32'hFFFFFFFF, '1);
    do_write(3, 32'h00000000, MAXL'(1));
    do_read(3);
    repeat (6) tick();

    do_write(7, 32'h11111111, '1);
    pulse_reset();
    wr_en = 1'b1;
    wr_addr = AW'(7);
    wr_lane_en = MAXL'(3);
    wr_data = {MAXL{32'h22222222}};
    rd_en = 1'b1;
    rd_addr = AW'(7);
    tick();
    idle();
    repeat (6) tick();
    @(negedge clk);
    for (int g = 0; g < NI; g++) check($sformatf("coll_cnt%0d", g), MAXW'(obs_cnt[g]), MAXW'(1));
    tick();

    pulse_reset();
    for (int k = 0; k < 20; k++) begin
      wr_en = 1'b1;
      rd_en = 1'b1;
      wr_addr = AW'(20);
      rd_addr = AW'(20);
      wr_lane_en = MAXL'($urandom_range(15, 1));
      for (int i = 0; i < MAXL; i++) wr_data[i*32 +: 32] = $urandom;
      tick();
    end
    idle();
    @(negedge clk);
    check("sat_cnt0", MAXW'(obs_cnt[0]), MAXW'(20));
    check("sat_cnt1", MAXW'(obs_cnt[1]), MAXW'(15));
    check("sat_cnt2", MAXW'(obs_cnt[2]), MAXW'(15));
    check("sat_cnt3", MAXW'(obs_cnt[3]), MAXW'(20));
    tick();
    repeat (6) tick();

    do_read(1);
    do_read(2);
    do_read(4);
    pulse_reset();
    repeat (6) tick();
    do_read(9);
    repeat (6) tick();

    for (int k = 0; k < 3000; k++) begin
      wr_en = ($urandom_range(1) == 1);
      rd_en = ($urandom_range(9) < 7);
      wr_addr = AW'($urandom_range(15));
      rd_addr = AW'($urandom_range(15));
      wr_lane_en = MAXL'($urandom);
      if ($urandom_range(3) == 0) wr_lane_en[3:0] = '0;
      for (int i = 0; i < MAXL; i++) wr_data[i*32 +: 32] = $urandom;
      tick();
    end
    idle();
    repeat (8) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
